// File: rtl/instruction_fetch_unit.sv
// LEGv8 instruction fetch unit: owns the PC, runs the instruction-memory handshake and
// holds each fetched word for the decoder until the datapath commits it.
module instruction_fetch_unit #(
    parameter int unsigned PC_WIDTH       = 64,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] startpc,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr,
    output logic [10:0]         opcode,
    output logic                instr_valid,
    input  logic                commit,
    input  logic                uncond_branch,
    input  logic                branch,
    input  logic                zero,
    input  logic [PC_WIDTH-1:0] signext_imm,
    output logic [PC_WIDTH-1:0] currentpc,
    output logic [31:0]         retired_count,
    output logic                fetch_error
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StHold,
        StError
    } state_e;

    localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

    state_e              r_state, w_state_next;
    logic [PC_WIDTH-1:0] r_pc, w_pc_next;
    logic [31:0]         r_instr, w_instr_next;
    logic [31:0]         r_retired, w_retired_next;
    logic [7:0]          r_wait, w_wait_next;
    logic [7:0]          w_wait_inc;
    logic                w_take;
    logic [PC_WIDTH-1:0] w_offset;
    logic [PC_WIDTH-1:0] w_next_pc;

    // Offset is in words; shifting drops the top two bits, matching modulo-2^PC_WIDTH wrap.
    assign w_take     = uncond_branch | (branch & zero);
    assign w_offset   = w_take ? (signext_imm << 2) : PC_WIDTH'(4);
    assign w_next_pc  = r_pc + w_offset;
    assign w_wait_inc = r_wait + 8'd1;

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_instr_next   = r_instr;
        w_retired_next = r_retired;
        w_wait_next    = r_wait;
        unique case (r_state)
            StIdle: begin
                w_state_next = StReq;
                w_wait_next  = '0;
            end
            StReq: begin
                if (imem_ack) begin
                    w_instr_next = imem_rdata;
                    w_state_next = StHold;
                end else begin
                    w_wait_next = w_wait_inc;
                    if (w_wait_inc == TimeoutLimit) begin
                        w_state_next = StError;
                    end
                end
            end
            StHold: begin
                if (commit) begin
                    w_pc_next      = w_next_pc;
                    w_retired_next = r_retired + 32'd1;
                    w_wait_next    = '0;
                    w_state_next   = StReq;
                end
            end
            StError: begin
                w_state_next = StError;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state   <= StIdle;
            r_pc      <= startpc;
            r_instr   <= '0;
            r_retired <= '0;
            r_wait    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_instr   <= w_instr_next;
            r_retired <= w_retired_next;
            r_wait    <= w_wait_next;
        end
    end

    // Handshake outputs decode the state register only, so no input reaches them combinationally.
    assign imem_req      = (r_state == StReq);
    assign instr_valid   = (r_state == StHold);
    assign fetch_error   = (r_state == StError);
    assign imem_addr     = r_pc;
    assign currentpc     = r_pc;
    assign instr         = r_instr;
    assign opcode        = r_instr[31:21];
    assign retired_count = r_retired;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a randomized
// fetch/commit loop checked against a next-PC arithmetic model.
module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] startpc = 64'h0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [10:0] opcode;
    logic        instr_valid;
    logic        commit = 1'b0;
    logic        uncond_branch = 1'b0;
    logic        branch = 1'b0;
    logic        zero = 1'b0;
    logic [63:0] signext_imm = 64'h0;
    logic [63:0] currentpc;
    logic [31:0] retired_count;
    logic        fetch_error;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_pc;
    logic [31:0] exp_cnt;

    instruction_fetch_unit #(
        .PC_WIDTH      (64),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .startpc      (startpc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .opcode       (opcode),
        .instr_valid  (instr_valid),
        .commit       (commit),
        .uncond_branch(uncond_branch),
        .branch       (branch),
        .zero         (zero),
        .signext_imm  (signext_imm),
        .currentpc    (currentpc),
        .retired_count(retired_count),
        .fetch_error  (fetch_error)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: time %0t reached, required finish before 1000000", $time);
        $fatal(1, "watchdog expired");
    end

    // Architectural next-PC rule: word offset for taken branches, else the next word.
    function automatic logic [63:0] model_next(input logic [63:0] pc, input logic u,
                                               input logic b, input logic z,
                                               input logic [63:0] imm);
        if (u || (b && z)) return pc + imm * 64'd4;
        return pc + 64'd4;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Leaves the DUT in its first request cycle at pc.
    task automatic do_reset(input logic [63:0] pc);
        imem_ack = 1'b0;
        commit   = 1'b0;
        reset    = 1'b1;
        startpc  = pc;
        tick();
        reset = 1'b0;
        tick();
        exp_pc  = pc;
        exp_cnt = 0;
    endtask

    task automatic fetch(input int waits, input logic [31:0] data);
        repeat (waits) tick();
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
    endtask

    task automatic do_commit(input logic u, input logic b, input logic z, input logic [63:0] imm);
        uncond_branch = u;
        branch        = b;
        zero          = z;
        signext_imm   = imm;
        commit        = 1'b1;
        tick();
        commit        = 1'b0;
        uncond_branch = $urandom_range(0, 1);
        branch        = $urandom_range(0, 1);
        zero          = $urandom_range(0, 1);
        signext_imm   = {$urandom, $urandom};
        exp_pc        = model_next(exp_pc, u, b, z, imm);
        exp_cnt       = exp_cnt + 1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        startpc    = 64'h40;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        commit     = 1'b1;
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (fetch_error !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", fetch_error); end
        checks++; if (currentpc !== 64'h40) begin errors++; $display("FAIL reset_pc: got %h want 40", currentpc); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
        checks++; if (retired_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %0d want 0", retired_count); end
        reset    = 1'b0;
        imem_ack = 1'b0;
        commit   = 1'b0;
        tick();
        exp_pc  = 64'h40;
        exp_cnt = 0;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 64'h40) begin errors++; $display("FAIL first_addr: got %h want 40", imem_addr); end
    endtask

    task automatic test_fetch_latency();
        tick();
        tick();
        checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL wait_state: got req=%b valid=%b want req=1 valid=0", imem_req, instr_valid); end
        fetch(0, 32'hF84003E9);
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL ack_valid: got %b want 1", instr_valid); end
        checks++; if (instr !== 32'hF84003E9) begin errors++; $display("FAIL ack_instr: got %h want F84003E9", instr); end
        checks++; if (opcode !== 11'h7C2) begin errors++; $display("FAIL ack_opcode: got %h want 7C2", opcode); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req: got %b want 0", imem_req); end
    endtask

    task automatic test_seq_commit();
        imem_ack   = 1'b1;
        imem_rdata = 32'h12345678;
        tick();
        tick();
        imem_ack = 1'b0;
        checks++; if (instr !== 32'hF84003E9 || instr_valid !== 1'b1) begin errors++; $display("FAIL hold_stable: got %h/%b want F84003E9/1", instr, instr_valid); end
        do_commit(1'b0, 1'b0, 1'b0, 64'h10);
        checks++; if (currentpc !== 64'h44) begin errors++; $display("FAIL seq_pc: got %h want 44", currentpc); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h44) begin errors++; $display("FAIL seq_req: got req=%b addr=%h want 1/44", imem_req, imem_addr); end
        checks++; if (retired_count !== 32'd1) begin errors++; $display("FAIL seq_count: got %0d want 1", retired_count); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq_valid: got %b want 0", instr_valid); end
    endtask

    task automatic test_cond_branch();
        do_reset(64'h100);
        fetch(0, $urandom);
        do_commit(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        checks++; if (currentpc !== 64'hF0) begin errors++; $display("FAIL cbr_taken: got %h want F0", currentpc); end
        do_reset(64'h100);
        fetch(1, $urandom);
        do_commit(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
        checks++; if (currentpc !== 64'h104) begin errors++; $display("FAIL cbr_not_taken: got %h want 104", currentpc); end
    endtask

    task automatic test_uncond();
        do_reset(64'h200);
        fetch(0, $urandom);
        do_commit(1'b1, 1'b0, 1'b0, 64'h3);
        checks++; if (currentpc !== 64'h20C) begin errors++; $display("FAIL ubr_pc: got %h want 20C", currentpc); end
        commit = 1'b1;
        repeat (3) tick();
        commit = 1'b0;
        checks++; if (currentpc !== 64'h20C || retired_count !== 32'd1) begin errors++; $display("FAIL spurious_commit: got pc=%h cnt=%0d want 20C/1", currentpc, retired_count); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL spurious_req: got %b want 1", imem_req); end
    endtask

    task automatic test_timeout();
        int n;
        do_reset(64'h300);
        n = 0;
        while (imem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++; if (n !== 15) begin errors++; $display("FAIL timeout_cycles: got %0d want 15", n); end
        checks++; if (fetch_error !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL timeout_state: got err=%b req=%b want 1/0", fetch_error, imem_req); end
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFEF00D;
        commit     = 1'b1;
        repeat (3) tick();
        imem_ack = 1'b0;
        commit   = 1'b0;
        checks++; if (fetch_error !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL err_sticky: got err=%b valid=%b want 1/0", fetch_error, instr_valid); end
        checks++; if (instr !== 32'h0 || currentpc !== 64'h300 || retired_count !== 32'h0) begin errors++; $display("FAIL err_frozen: got %h/%h/%0d want 0/300/0", instr, currentpc, retired_count); end
        do_reset(64'h400);
        checks++; if (fetch_error !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h400) begin errors++; $display("FAIL err_recover: got err=%b req=%b addr=%h want 0/1/400", fetch_error, imem_req, imem_addr); end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset(64'h500);
        fetch(0, 32'h12345678);
        do_commit(1'b0, 1'b0, 1'b0, 64'h0);
        tick();
        reset      = 1'b1;
        startpc    = 64'h600;
        imem_ack   = 1'b1;
        imem_rdata = 32'hA5A5A5A5;
        tick();
        checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got req=%b valid=%b want 0/0", imem_req, instr_valid); end
        checks++; if (instr !== 32'h0 || currentpc !== 64'h600 || retired_count !== 32'h0) begin errors++; $display("FAIL midrst_regs: got %h/%h/%0d want 0/600/0", instr, currentpc, retired_count); end
        reset    = 1'b0;
        imem_ack = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h600) begin errors++; $display("FAIL midrst_refetch: got req=%b addr=%h want 1/600", imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        do_reset(64'hFFFF_FFFF_FFFF_FFFC);
        fetch(0, $urandom);
        do_commit(1'b0, 1'b0, 1'b0, 64'h0);
        checks++; if (currentpc !== 64'h0) begin errors++; $display("FAIL wrap_seq: got %h want 0", currentpc); end
        fetch(2, $urandom);
        do_commit(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        checks++; if (currentpc !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_back: got %h want FFFFFFFFFFFFFFFC", currentpc); end
    endtask

    task automatic test_random();
        logic [31:0] data;
        do_reset({$urandom, $urandom} & ~64'h3);
        for (int t = 0; t < 30; t++) begin
            for (int w = $urandom_range(0, 6); w > 0; w--) begin
                commit = $urandom_range(0, 1);
                tick();
            end
            commit = 1'b0;
            checks++; if (imem_req !== 1'b1 || currentpc !== exp_pc) begin errors++; $display("FAIL rnd_req[%0d]: got req=%b pc=%h want 1/%h", t, imem_req, currentpc, exp_pc); end
            data = $urandom;
            fetch(0, data);
            checks++; if (instr !== data || opcode !== data[31:21] || instr_valid !== 1'b1) begin errors++; $display("FAIL rnd_fetch[%0d]: got %h/%h/%b want %h/%h/1", t, instr, opcode, instr_valid, data, data[31:21]); end
            for (int h = $urandom_range(0, 3); h > 0; h--) begin
                imem_ack   = $urandom_range(0, 1);
                imem_rdata = $urandom;
                tick();
            end
            imem_ack = 1'b0;
            checks++; if (instr !== data || instr_valid !== 1'b1) begin errors++; $display("FAIL rnd_hold[%0d]: got %h/%b want %h/1", t, instr, instr_valid, data); end
            do_commit($urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
                      ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : 64'($signed($urandom_range(0, 64)) - 32));
            checks++; if (currentpc !== exp_pc || retired_count !== exp_cnt) begin errors++; $display("FAIL rnd_commit[%0d]: got pc=%h cnt=%0d want %h/%0d", t, currentpc, retired_count, exp_pc, exp_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_latency();
        test_seq_commit();
        test_cond_branch();
        test_uncond();
        test_timeout();
        test_reset_mid_fetch();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream neighbour of the main decoder in the single-cycle LEGv8 processor.
- Owns the program counter and the instruction-memory request/acknowledge handshake.
- Holds each fetched instruction stable and presents its opcode field (instr[31:21]) to the decoder until the datapath commits.
- On commit, computes the next PC from the decoder's uncond_branch/branch outputs and the ALU zero flag, then fetches again.

Parameters:
- PC_WIDTH, 64: width of PC, addresses and the branch offset.
- TIMEOUT_CYCLES, 15: maximum cycles spent waiting for imem_ack before a fetch error is raised; legal range 1..255.

Ports:
- CLK  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- startpc  input  PC_WIDTH  PC value loaded while reset is high.
- imem_req  output  1  instruction-memory read request.
- imem_addr  output  PC_WIDTH  read address; always equal to currentpc.
- imem_ack  input  1  memory acknowledge; imem_rdata is valid in the same cycle.
- imem_rdata  input  32  instruction word.
- instr  output  32  held instruction word.
- opcode  output  11  instr[31:21], feeds the decoder.
- instr_valid  output  1  instr/opcode are valid for the current PC.
- commit  input  1  datapath has finished the current instruction.
- uncond_branch  input  1  from decoder.
- branch  input  1  from decoder (conditional branch).
- zero  input  1  ALU zero flag.
- signext_imm  input  PC_WIDTH  sign-extended branch offset in words.
- currentpc  output  PC_WIDTH  PC of the instruction being fetched or held.
- retired_count  output  32  number of accepted commits.
- fetch_error  output  1  sticky timeout flag.

Behaviour:
- Reset (sampled on the CLK edge while reset=1):
  - currentpc<=startpc; state<=IDLE; instr<=0; retired_count<=0; wait counter<=0.
  - instr_valid, imem_req and fetch_error are driven 0.
  - Reset overrides every other input, including imem_ack and commit in the same cycle.
  - Reset mid-fetch abandons the request; the next edge already shows imem_req=0.
- States:
  - IDLE: imem_req=0. Go to REQ on the next edge. Only entered from reset.
  - REQ: imem_req=1; imem_addr and currentpc held constant.
    - If imem_ack=1: instr<=imem_rdata, go to HOLD.
    - Otherwise increment the wait counter. When the counter reaches TIMEOUT_CYCLES without an ack, go to ERROR.
    - The counter clears on entry to REQ.
  - HOLD: instr_valid=1, imem_req=0.
    - If commit=1: currentpc<=next_pc; retired_count<=retired_count+1 (wraps at 2^32); go to REQ.
    - Otherwise hold all outputs.
  - ERROR: imem_req=0, instr_valid=0, fetch_error=1. Left only by reset.
- next_pc:
  - currentpc + (signext_imm << 2) if uncond_branch=1 or (branch=1 and zero=1).
  - Otherwise currentpc + 4.
  - Arithmetic is modulo 2^PC_WIDTH; overflow and negative offsets wrap silently.
  - uncond_branch takes priority; branch and zero are don't-care when it is set.
  - branch, zero and signext_imm are sampled only on the commit edge.
- Handshake rules:
  - imem_ack outside REQ is ignored.
  - commit outside HOLD is ignored.
  - imem_rdata is captured only on the ack edge.
- Latency:
  - A zero-wait ack (ack in the first REQ cycle) gives instr_valid=1 on the next cycle.
  - Commit gives imem_req=1 with the new PC on the following cycle.
  - Peak throughput is one instruction per 2 cycles.
- Outputs are registered or decoded from the state register only; there is no combinational path from any input to imem_req or instr_valid.
- opcode is always instr[31:21], including while instr_valid=0.

Test Plan:
- Reset with startpc=0x40, ack returned 2 cycles after the request with rdata=0xF84003E9 -> imem_addr=0x40, instr_valid=1 one cycle after ack, opcode=0x7C2.
- In HOLD at pc=0x40, commit with branch=0, uncond_branch=0 -> currentpc=0x44, imem_req=1 next cycle, retired_count=1.
- At pc=0x100, commit with branch=1, zero=1, signext_imm=-4 (all ones except low bits 0xFFFFFFFFFFFFFFFC) -> currentpc=0xF0. Repeat with zero=0 -> currentpc=0x104.
- uncond_branch=1, branch=0, zero=0, signext_imm=3 at pc=0x200 -> currentpc=0x20C. Spurious commit pulses during REQ leave PC and count unchanged.
- Never assert ack with TIMEOUT_CYCLES=15 -> fetch_error=1 after 15 REQ cycles, imem_req=0. A later ack or commit has no effect. Reset clears the error and refetches startpc.
- Assert reset during REQ while ack=1 -> instr stays 0, instr_valid=0, PC reloads startpc. Also check currentpc=0xFFFFFFFFFFFFFFFC with a sequential commit wraps to 0x0.
